inspection_sorter: RTL and testbench
====================================

INSPECTION_SORTER -- requirements
Module: inspection_sorter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 4, number of cycles a diverter gate is held (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, width of the approved and rejected counters.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port E  input  2  inspection code from the upstream inspection FSM: 00 nada, 01 avanzar, 10 rechazado, 11 aprobado.
REQ-006 SHALL have port clear_counts  input  1  synchronous clear of the counters and the overrun flag.
REQ-007 SHALL have port motor  output  1  conveyor run command.
REQ-008 SHALL have port gate_accept  output  1  accept diverter drive.
REQ-009 SHALL have port gate_reject  output  1  reject diverter drive.
REQ-010 SHALL have port approved_count  output  CNT_W  saturating count of accepted verdicts.
REQ-011 SHALL have port rejected_count  output  CNT_W  saturating count of rejected verdicts.
REQ-012 SHALL have port overrun  output  1  sticky flag for a dropped verdict.
REQ-013 SHALL have port so_current_state  output  2  current state (sort_state_t) for debug.

Function
REQ-014 SHALL implement a Moore FSM with states so_IDLE, so_RUN, so_ACCEPT, so_REJECT; motor, gate_accept and gate_reject SHALL be decoded from state only.
REQ-015 Outputs: so_IDLE all 0; so_RUN motor=1; so_ACCEPT motor=1, gate_accept=1; so_REJECT motor=1, gate_reject=1.
REQ-016 so_IDLE/so_RUN transitions on sampled E: 00 -> so_IDLE; 01 -> so_RUN; 11 -> so_ACCEPT; 10 -> so_REJECT.
REQ-017 A verdict sampled at edge k SHALL be reflected in state and outputs immediately after edge k (one-cycle latency).
REQ-018 On entry to so_ACCEPT or so_REJECT the gate timer SHALL load GATE_CYCLES-1; it decrements each cycle; the gate state SHALL persist exactly GATE_CYCLES cycles.
REQ-019 A verdict (10/11) sampled while the timer is nonzero SHALL be stored in a one-deep pending register if it is empty; if it is full, the verdict SHALL be dropped and overrun set to 1.
REQ-020 At timer==0: a pending verdict SHALL be served first (enter its gate state, reload timer, clear pending); else a verdict on E that cycle SHALL be served directly; else E==01 -> so_RUN, otherwise so_IDLE.
REQ-021 At timer==0 with pending valid and a new verdict on E, the new verdict SHALL go into pending (no overrun).
REQ-022 Counters SHALL increment in the cycle a verdict is accepted (served or queued); dropped verdicts SHALL NOT count.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 clear_counts SHALL zero both counters and overrun on the next edge, taking priority over a simultaneous increment; it SHALL NOT affect state, timer or pending.
REQ-025 E codes 01/00 during a gate state SHALL NOT shorten the gate.

Reset
REQ-026 When reset==0 at a clock edge: state so_IDLE, timer 0, pending empty, both counters 0, overrun 0; all outputs 0 after that edge.
REQ-027 Reset mid-gate SHALL abort the gate and discard the pending verdict with no count change beyond the reset clear.

Structure
REQ-028 Package sorter_pkg SHALL hold sort_state_t and the E code constants E_NADA, E_AVANZAR, E_RECHAZO, E_APROBADO, shared with the inspection FSM.
REQ-029 A sub-module sat_counter (parameter width, inc, clr, count) SHALL be instantiated twice.

Verification
REQ-030 Reset, then E=01 for 3 cycles, then 00 -> motor=1 for 3 cycles, then so_IDLE, all outputs 0.
REQ-031 E=11 for one cycle, GATE_CYCLES=4 -> gate_accept=1 for exactly 4 cycles, approved_count=1, then so_IDLE.
REQ-032 E=10, then E=11 two cycles later, then E=10 one cycle after that -> reject gate 4 cycles, accept gate 4 cycles, third verdict dropped, overrun=1, rejected_count=1, approved_count=1.
REQ-033 CNT_W=2, 5 accepted verdicts spaced 6 cycles apart -> approved_count saturates at 3; clear_counts together with a verdict -> count 0, overrun 0.
REQ-034 Reset asserted in gate cycle 2 with a pending verdict -> next cycle so_IDLE, gate_reject=0, pending never served, counters 0.

Source files
------------

// File: rtl/sorter_pkg.sv
// sorter_pkg: sort states and inspection codes shared with the inspection FSM
package sorter_pkg;
    typedef enum logic [1:0] {so_IDLE = 2'd0, so_RUN = 2'd1, so_ACCEPT = 2'd2, so_REJECT = 2'd3} sort_state_t;
    localparam logic [1:0] E_NADA     = 2'b00;
    localparam logic [1:0] E_AVANZAR  = 2'b01;
    localparam logic [1:0] E_RECHAZO  = 2'b10;
    localparam logic [1:0] E_APROBADO = 2'b11;
    function automatic sort_state_t gate_of(input logic acc);
        return acc ? so_ACCEPT : so_REJECT;
    endfunction
endpackage

// File: rtl/inspection_sorter_if.sv
// inspection_sorter_if: inspection code in, conveyor/diverter drives and statistics out
interface inspection_sorter_if #(parameter int CNT_W = 8);
    import sorter_pkg::*;
    logic [1:0]       E;
    logic             clear_counts;
    logic             motor;
    logic             gate_accept;
    logic             gate_reject;
    logic [CNT_W-1:0] approved_count;
    logic [CNT_W-1:0] rejected_count;
    logic             overrun;
    sort_state_t      so_current_state;
    modport master (output E, clear_counts,
                    input motor, gate_accept, gate_reject, approved_count, rejected_count, overrun, so_current_state);
    modport slave  (input E, clear_counts,
                    output motor, gate_accept, gate_reject, approved_count, rejected_count, overrun, so_current_state);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones, cleared by reset or clr
module sat_counter #(parameter int width = 8) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] count
);
    always_ff @(posedge clk) begin
        if (!reset || clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/inspection_sorter.sv
// inspection_sorter: conveyor FSM holding a diverter gate per verdict, one-deep verdict queue
module inspection_sorter import sorter_pkg::*; #(
    parameter int GATE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    inspection_sorter_if.slave bus
);
    localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES - 1);
    sort_state_t state, nxt;
    logic [7:0] timer, nxt_timer;
    logic pend_valid, pend_acc, nxt_pend_valid, nxt_pend_acc;
    logic verdict, v_acc, busy, drop, inc_a, inc_r;
    assign verdict = bus.E[1];
    assign v_acc = bus.E == E_APROBADO;
    assign busy = timer != 8'd0;
    assign drop = busy && pend_valid && verdict;
    assign inc_a = verdict && v_acc && !drop;
    assign inc_r = verdict && !v_acc && !drop;
    assign bus.so_current_state = state;
    always_comb begin
        nxt = state;
        nxt_timer = busy ? timer - 8'd1 : 8'd0;
        nxt_pend_valid = pend_valid;
        nxt_pend_acc = pend_acc;
        if (busy) begin
            if (verdict && !pend_valid) begin
                nxt_pend_valid = 1'b1;
                nxt_pend_acc = v_acc;
            end
        end else if (pend_valid) begin
            nxt = gate_of(pend_acc);
            nxt_timer = GATE_LOAD;
            nxt_pend_valid = verdict;
            nxt_pend_acc = v_acc;
        end else if (verdict) begin
            nxt = gate_of(v_acc);
            nxt_timer = GATE_LOAD;
        end else begin
            nxt = bus.E == E_AVANZAR ? so_RUN : so_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= so_IDLE;
            timer <= 8'd0;
            pend_valid <= 1'b0;
            pend_acc <= 1'b0;
            bus.motor <= 1'b0;
            bus.gate_accept <= 1'b0;
            bus.gate_reject <= 1'b0;
        end else begin
            state <= nxt;
            timer <= nxt_timer;
            pend_valid <= nxt_pend_valid;
            pend_acc <= nxt_pend_acc;
            bus.motor <= nxt != so_IDLE;
            bus.gate_accept <= nxt == so_ACCEPT;
            bus.gate_reject <= nxt == so_REJECT;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset || bus.clear_counts) bus.overrun <= 1'b0;
        else if (drop) bus.overrun <= 1'b1;
    end
    sat_counter #(.width(CNT_W)) u_approved (
        .clk(clk), .reset(reset), .inc(inc_a), .clr(bus.clear_counts), .count(bus.approved_count)
    );
    sat_counter #(.width(CNT_W)) u_rejected (
        .clk(clk), .reset(reset), .inc(inc_r), .clr(bus.clear_counts), .count(bus.rejected_count)
    );
endmodule

// File: tb/tb_inspection_sorter.sv
// tb_inspection_sorter: directed vectors with a scoreboard queue checked by a per-cycle monitor
module tb_inspection_sorter;
    import sorter_pkg::*;
    localparam int GC = 4;
    localparam int CW = 2;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    inspection_sorter_if #(.CNT_W(CW)) bus();
    inspection_sorter #(.GATE_CYCLES(GC), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        string       name;
        sort_state_t st;
        logic [CW-1:0] ac;
        logic [CW-1:0] rc;
        logic        ov;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    int total = 0;
    int bad = 0;
    task automatic step(input logic rn, input logic [1:0] e, input logic clr, input sort_state_t st,
                        input int ac, input int rc, input logic ov, input string name);
        @(negedge clk);
        reset = rn;
        bus.E = e;
        bus.clear_counts = clr;
        q.push_back('{name: name, st: st, ac: CW'(ac), rc: CW'(rc), ov: ov});
    endtask
    task automatic rep(input int n, input logic [1:0] e, input sort_state_t st,
                       input int ac, input int rc, input logic ov, input string name);
        for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, st, ac, rc, ov, name);
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            cur = q.pop_front();
            total++;
            if ({bus.so_current_state, bus.motor, bus.gate_accept, bus.gate_reject,
                 bus.approved_count, bus.rejected_count, bus.overrun} !==
                {cur.st, cur.st != so_IDLE, cur.st == so_ACCEPT, cur.st == so_REJECT, cur.ac, cur.rc, cur.ov}) begin
                bad++;
                $display("FAIL %s: got st=%0d mar=%b%b%b ac=%0d rc=%0d ov=%b, want st=%0d mar=%b%b%b ac=%0d rc=%0d ov=%b",
                         cur.name, bus.so_current_state, bus.motor, bus.gate_accept, bus.gate_reject,
                         bus.approved_count, bus.rejected_count, bus.overrun,
                         cur.st, cur.st != so_IDLE, cur.st == so_ACCEPT, cur.st == so_REJECT, cur.ac, cur.rc, cur.ov);
            end
        end
    end
    initial begin
        bus.E = E_NADA;
        bus.clear_counts = 1'b0;
        step(1'b0, E_NADA, 1'b0, so_IDLE, 0, 0, 1'b0, "reset");
        step(1'b0, E_APROBADO, 1'b0, so_IDLE, 0, 0, 1'b0, "reset_with_verdict");
        rep(3, E_AVANZAR, so_RUN, 0, 0, 1'b0, "run");
        rep(1, E_NADA, so_IDLE, 0, 0, 1'b0, "run_stop");
        rep(1, E_APROBADO, so_ACCEPT, 1, 0, 1'b0, "accept_enter");
        rep(3, E_NADA, so_ACCEPT, 1, 0, 1'b0, "accept_hold");
        rep(1, E_NADA, so_IDLE, 1, 0, 1'b0, "accept_exit");
        rep(1, E_APROBADO, so_ACCEPT, 2, 0, 1'b0, "avanzar_gate_enter");
        rep(3, E_AVANZAR, so_ACCEPT, 2, 0, 1'b0, "avanzar_no_shorten");
        rep(1, E_AVANZAR, so_RUN, 2, 0, 1'b0, "gate_to_run");
        step(1'b1, E_NADA, 1'b1, so_IDLE, 0, 0, 1'b0, "clear1");
        rep(1, E_APROBADO, so_ACCEPT, 1, 0, 1'b0, "b2b_accept");
        rep(3, E_NADA, so_ACCEPT, 1, 0, 1'b0, "b2b_hold");
        rep(1, E_RECHAZO, so_REJECT, 1, 1, 1'b0, "b2b_direct_reject");
        rep(3, E_NADA, so_REJECT, 1, 1, 1'b0, "b2b_reject_hold");
        rep(1, E_NADA, so_IDLE, 1, 1, 1'b0, "b2b_exit");
        step(1'b1, E_NADA, 1'b1, so_IDLE, 0, 0, 1'b0, "clear2");
        rep(1, E_RECHAZO, so_REJECT, 0, 1, 1'b0, "ovr_reject");
        rep(1, E_NADA, so_REJECT, 0, 1, 1'b0, "ovr_hold");
        rep(1, E_APROBADO, so_REJECT, 1, 1, 1'b0, "ovr_queue");
        rep(1, E_RECHAZO, so_REJECT, 1, 1, 1'b1, "ovr_drop");
        rep(4, E_NADA, so_ACCEPT, 1, 1, 1'b1, "ovr_pending_served");
        rep(1, E_NADA, so_IDLE, 1, 1, 1'b1, "ovr_exit");
        step(1'b1, E_NADA, 1'b1, so_IDLE, 0, 0, 1'b0, "clear3");
        for (int k = 0; k < 5; k++) begin
            rep(1, E_APROBADO, so_ACCEPT, (k + 1 > 3) ? 3 : k + 1, 0, 1'b0, "sat_enter");
            rep(3, E_NADA, so_ACCEPT, (k + 1 > 3) ? 3 : k + 1, 0, 1'b0, "sat_hold");
            rep(2, E_NADA, so_IDLE, (k + 1 > 3) ? 3 : k + 1, 0, 1'b0, "sat_idle");
        end
        rep(1, E_APROBADO, so_ACCEPT, 3, 0, 1'b0, "clr_gate");
        rep(1, E_APROBADO, so_ACCEPT, 3, 0, 1'b0, "clr_queue");
        rep(1, E_APROBADO, so_ACCEPT, 3, 0, 1'b1, "clr_drop");
        rep(1, E_NADA, so_ACCEPT, 3, 0, 1'b1, "clr_last");
        step(1'b1, E_APROBADO, 1'b1, so_ACCEPT, 0, 0, 1'b0, "clr_with_verdict");
        rep(3, E_NADA, so_ACCEPT, 0, 0, 1'b0, "clr_hold");
        rep(4, E_NADA, so_ACCEPT, 0, 0, 1'b0, "clr_pending_kept");
        rep(1, E_NADA, so_IDLE, 0, 0, 1'b0, "clr_exit");
        step(1'b1, E_RECHAZO, 1'b1, so_REJECT, 0, 0, 1'b0, "clr_idle_verdict");
        rep(3, E_NADA, so_REJECT, 0, 0, 1'b0, "clr_idle_hold");
        rep(1, E_NADA, so_IDLE, 0, 0, 1'b0, "clr_idle_exit");
        rep(1, E_RECHAZO, so_REJECT, 0, 1, 1'b0, "rst_gate");
        rep(1, E_APROBADO, so_REJECT, 1, 1, 1'b0, "rst_queue");
        step(1'b0, E_NADA, 1'b0, so_IDLE, 0, 0, 1'b0, "rst_mid_gate");
        rep(5, E_NADA, so_IDLE, 0, 0, 1'b0, "rst_pending_gone");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
